// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK per instruction
// class, with memory wait timeout, stall holding and a retired-instruction counter.
module multicycle_ctrl #(
  parameter int unsigned SKIP_UNUSED  = 1,
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_branch,
  input  logic             is_jump,
  input  logic             is_halt,
  input  logic             mem_ready,
  output logic             pc_inc,
  output logic             ir_write,
  output logic             alu_op,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [2:0]       state,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] instr_count
);

  localparam int unsigned WAIT_W   = (MEM_WAIT_MAX > 1) ? $clog2(MEM_WAIT_MAX) : 1;
  localparam int unsigned WaitLast = (MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0;

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMemory    = 3'd3,
    StWriteback = 3'd4,
    StHalt      = 3'd5,
    StError     = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    ClsAlu,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsHalt
  } cls_e;

  state_e            r_state;
  cls_e              r_cls;
  cls_e              w_dec_cls;
  logic [WAIT_W-1:0] r_wait;
  logic [CNT_W-1:0]  r_count;
  logic              w_skip;
  logic              w_mem_cls;
  logic              w_timeout;

  assign w_skip    = (SKIP_UNUSED != 0);
  assign w_mem_cls = (r_cls == ClsLoad) || (r_cls == ClsStore);
  // Timeout fires on the MEM_WAIT_MAX-th consecutive low cycle; a ready in that cycle still wins.
  assign w_timeout = (MEM_WAIT_MAX != 0) && !mem_ready && (r_wait == WAIT_W'(WaitLast));

  always_comb begin
    if (is_halt)                    w_dec_cls = ClsHalt;
    else if (is_load)               w_dec_cls = ClsLoad;
    else if (is_store)              w_dec_cls = ClsStore;
    else if (is_branch || is_jump)  w_dec_cls = ClsBranch;
    else                            w_dec_cls = ClsAlu;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StFetch;
      r_cls   <= ClsAlu;
      r_wait  <= '0;
      r_count <= '0;
    end else begin
      // Counter is cleared on every cycle that is not a continued wait, so entry clears it.
      r_wait <= '0;
      case (r_state)
        StFetch: begin
          if (mem_ready)      r_state <= StDecode;
          else if (w_timeout) r_state <= StError;
          else                r_wait  <= r_wait + WAIT_W'(1);
        end
        StDecode: begin
          if (!stall) begin
            r_cls   <= w_dec_cls;
            r_state <= StExecute;
          end
        end
        StExecute: begin
          if (!stall) begin
            if (r_cls == ClsHalt) begin
              r_state <= StHalt;
            end else if (!w_skip || w_mem_cls) begin
              r_state <= StMemory;
            end else if (r_cls == ClsBranch) begin
              r_state <= StFetch;
              r_count <= r_count + CNT_W'(1);
            end else begin
              r_state <= StWriteback;
            end
          end
        end
        StMemory: begin
          if (!w_mem_cls) begin
            r_state <= StWriteback;
          end else if (mem_ready) begin
            if (w_skip && (r_cls == ClsStore)) begin
              r_state <= StFetch;
              r_count <= r_count + CNT_W'(1);
            end else begin
              r_state <= StWriteback;
            end
          end else if (w_timeout) begin
            r_state <= StError;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        StWriteback: begin
          if (!stall) begin
            r_state <= StFetch;
            r_count <= r_count + CNT_W'(1);
          end
        end
        StHalt:  r_state <= StHalt;
        StError: r_state <= StError;
        default: r_state <= StError;
      endcase
    end
  end

  // Gated by rst_n so strobes drop the instant reset asserts, independent of the clock.
  always_comb begin
    pc_inc    = 1'b0;
    ir_write  = 1'b0;
    alu_op    = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    if (rst_n) begin
      case (r_state)
        StFetch: begin
          mem_read = 1'b1;
          pc_inc   = mem_ready;
          ir_write = mem_ready;
        end
        StExecute: alu_op = !stall;
        StMemory: begin
          mem_read  = (r_cls == ClsLoad);
          mem_write = (r_cls == ClsStore);
        end
        StWriteback: reg_write = !stall && ((r_cls == ClsLoad) || (r_cls == ClsAlu));
        default: ;
      endcase
    end
  end

  assign state       = r_state;
  assign halted      = (r_state == StHalt);
  assign mem_err     = (r_state == StError);
  assign instr_count = r_count;

endmodule
